mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single SoC RAM port between N bus masters: requester 0 = MMU page-table walker, 1 = CPU data port, 2 = CPU instruction fetch.
- Sits between cpu_inst and the RAM model/controller inside soc.
- Round-robin arbitration, one outstanding transaction.
- Read-response timeout so a hung RAM cannot deadlock the boot.

Parameters:
- N, 3, number of requesters (2..8).
- TIMEOUT, 1024, max cycles in WAIT before a forced error response.
- TW, 11, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_req  in  N  per-requester request; held with its fields until m_gnt
- m_we  in  N  per-requester write enable
- m_addr  in  N*32  packed addresses, requester k at [32k+31:32k]
- m_wdata  in  N*32  packed write data
- m_wstrb  in  N*4  packed byte strobes
- m_gnt  out  N  one-hot, 1-cycle pulse when the requester's transaction is accepted by memory
- m_rvalid  out  N  one-hot, 1-cycle read-data-valid
- m_rdata  out  32  read data broadcast, valid with m_rvalid
- m_err  out  1  pulses with m_rvalid on timeout
- mem_req  out  1  request to RAM
- mem_we  out  1  write enable to RAM
- mem_addr  out  32  address to RAM
- mem_wdata  out  32  write data to RAM
- mem_wstrb  out  4  byte strobes to RAM
- mem_ready  in  1  RAM accepts the request this cycle
- mem_rvalid  in  1  RAM read data valid
- mem_rdata  in  32  RAM read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=N-1 (requester 0 wins first). All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, m_gnt, m_rvalid, m_rdata, m_err. Timeout counter cleared. Reset mid-transaction abandons it; any late mem_rvalid is ignored in IDLE.
- IDLE:
  - If m_req!=0, the winner is the first set bit scanning from ptr+1 modulo N upward.
  - Next cycle: latch the winner index and its we/addr/wdata/wstrb, set ptr=winner, enter ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - mem_req=1 with the latched fields, held stable until mem_ready.
  - On mem_req&mem_ready: m_gnt[winner]=1 for that cycle, mem_req drops next cycle.
  - Write: go to IDLE.
  - Read: go to WAIT, clear the timeout counter.
  - Deassertion of m_req[winner] during ISSUE has no effect; the transaction is committed.
- WAIT:
  - On mem_rvalid: m_rvalid[winner]=1 and m_rdata=mem_rdata, registered (next cycle), then go to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without mem_rvalid: m_rvalid[winner]=1, m_rdata=32'hDEADBEEF, m_err=1, go to IDLE.
  - If mem_rvalid and the timeout coincide, real data wins and m_err=0.
- mem_rvalid outside WAIT: ignored.
- Throughput with zero-wait RAM:
  - Write = 2 cycles per transaction (IDLE, ISSUE).
  - Read = 3 cycles plus RAM latency.
- Fairness: every requester holding m_req is served within N grants.
- m_rdata holds its last value between responses.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds ports stat_clr (in, 1) and stat_grants (out, N*32, per-requester grant count) and stat_wait (out, 32).
  - stat_grants increments on each m_gnt pulse; wraps modulo 2^32.
  - stat_wait counts cycles in which any m_req bit is set but not granted that cycle.
  - stat_clr synchronously zeroes all counters and takes priority over a same-cycle increment.
  - All counters reset to 0 on rst_n.
- When undefined: these ports and counters are absent, behaviour otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum IDLE/ISSUE/WAIT (2 bits)
  - TIMEOUT_DATA=32'hDEADBEEF
  - requester index constants REQ_PTW=0, REQ_DMEM=1, REQ_IMEM=2
- One sub-module, rr_picker: combinational, in req[N-1:0] and ptr, out winner index and any_req. Instantiated once.

Test Plan:
- Reset then m_req=3'b111, RAM ready always, reads with 2-cycle latency -> grant order 0,1,2,0; each m_rvalid carries that requester's address-tagged data.
- Requester 1 writes addr 0x80001000, wdata 0xCAFEF00D, wstrb 4'hF; mem_ready held low 5 cycles -> mem_req and fields stable for 5 cycles, m_gnt[1] pulses in the ready cycle, no m_rvalid.
- Read with mem_rvalid never asserted, TIMEOUT=16 -> after 16 WAIT cycles: m_rvalid[winner]=1, m_rdata=0xDEADBEEF, m_err=1; next request serviced normally.
- rst_n pulsed low during WAIT, then a stray mem_rvalid -> no m_rvalid, all outputs 0, first post-reset grant goes to requester 0.
- m_req[2] held continuously, m_req[0] toggling every transaction -> requester 2 granted at least every second transaction (no starvation).
- With MEM_ARB_STATS_EN: 10 grants to requester 1, then stat_clr asserted in the same cycle as an 11th grant -> stat_grants[1] reads 10 before the clear and 0 after.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SoC RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Read data returned to the requester when the RAM never answers.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  // Requester slots as wired in the SoC.
  localparam int REQ_PTW  = 0;
  localparam int REQ_DMEM = 1;
  localparam int REQ_IMEM = 2;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first set request bit scanning upward from ptr+1,
// wrapping modulo N.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any_req
);

  // Scan from the farthest slot down so the nearest slot after ptr wins.
  always_comb begin
    int k;
    k      = 0;
    winner = '0;
    for (int i = N; i >= 1; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) winner = PW'(k);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single SoC RAM port between N masters, round-robin,
// one outstanding transaction, with a read-response timeout.
// Optional grant/wait statistics: define MEM_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no transaction; pick a winner when any request is pending
// ISSUE | mem_req driven with latched fields until mem_ready
// WAIT  | read accepted; waiting for mem_rvalid or the timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N       = 3,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    m_req,
  input  logic [N-1:0]    m_we,
  input  logic [N*32-1:0] m_addr,
  input  logic [N*32-1:0] m_wdata,
  input  logic [N*4-1:0]  m_wstrb,
  output logic [N-1:0]    m_gnt,
  output logic [N-1:0]    m_rvalid,
  output logic [31:0]     m_rdata,
  output logic            m_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [N*32-1:0] stat_grants,
  output logic [31:0]     stat_wait
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;

  logic [1:0]    state_q;
  logic [PW-1:0] ptr_q, win_q, pick_idx;
  logic          any_req;
  logic [TW-1:0] tmo_q;
  logic          tmo_done;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    wstrb_q;
  logic [N-1:0]  win_onehot;
  logic          accept;

  rr_picker #(.N(N), .PW(PW)) u_picker (
    .req     (m_req),
    .ptr     (ptr_q),
    .winner  (pick_idx),
    .any_req (any_req)
  );

  // One-hot form of the latched winner for grant/response steering.
  always_comb begin
    win_onehot        = '0;
    win_onehot[win_q] = 1'b1;
  end

  assign accept    = (state_q == ST_ISSUE) && mem_ready;
  assign tmo_done  = (tmo_q == TW'(TIMEOUT - 1));
  assign mem_req   = (state_q == ST_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign m_gnt     = accept ? win_onehot : '0;

  // Transaction FSM: latch winner fields, issue, then wait for read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(N - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            win_q   <= pick_idx;
            ptr_q   <= pick_idx;
            we_q    <= m_we[pick_idx];
            addr_q  <= m_addr[pick_idx*32 +: 32];
            wdata_q <= m_wdata[pick_idx*32 +: 32];
            wstrb_q <= m_wstrb[pick_idx*4 +: 4];
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            if (we_q) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT;
              tmo_q   <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid || tmo_done) state_q <= ST_IDLE;
          else                        tmo_q   <= tmo_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Registered read response; real data beats a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rvalid <= '0;
      m_rdata  <= '0;
      m_err    <= 1'b0;
    end else begin
      m_rvalid <= '0;
      m_err    <= 1'b0;
      if (state_q == ST_WAIT) begin
        if (mem_rvalid) begin
          m_rvalid <= win_onehot;
          m_rdata  <= mem_rdata;
        end else if (tmo_done) begin
          m_rvalid <= win_onehot;
          m_rdata  <= TIMEOUT_DATA;
          m_err    <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Per-requester grant counters and pending-but-not-granted cycle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_wait   <= '0;
    end else if (stat_clr) begin
      stat_grants <= '0;
      stat_wait   <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_gnt[k]) stat_grants[k*32 +: 32] <= stat_grants[k*32 +: 32] + 32'd1;
      end
      if (|(m_req & ~m_gnt)) stat_wait <= stat_wait + 32'd1;
    end
  end
`endif

endmodule
